// File: rtl/covox_pkg.sv
// -----------------------------------------------------------------------------
// covox_pkg
// Constants shared by the audio back-end and the port decoder of the
// dual-YM2149 board, plus the mixer helper used by covox_sd_dac.
//   MIX_W      : width of the unsigned mix word fed to the modulator
//   ACC_W      : width of the sigma-delta accumulator (carry bit on top)
//   COVOX_PORT : low byte of the Covox sample port
//   BEEP_PORT  : low byte of the beeper/tapeout port
// -----------------------------------------------------------------------------
package covox_pkg;

    localparam int MIX_W = 9;
    localparam int ACC_W = 10;

    localparam logic [7:0] COVOX_PORT = 8'hFB;
    localparam logic [7:0] BEEP_PORT  = 8'hFE;

    // Sum of the Covox sample and the two fixed-level sources. With
    // beep_lvl + tape_lvl <= 256 the result always fits in MIX_W bits.
    function automatic logic [MIX_W-1:0] mix_sum(
        input logic [7:0]       smp,
        input logic             beep,
        input logic             tape,
        input logic [MIX_W-1:0] beep_lvl,
        input logic [MIX_W-1:0] tape_lvl
    );
        logic [MIX_W-1:0] acc;
        acc = {1'b0, smp};
        if (beep) acc = acc + beep_lvl;
        if (tape) acc = acc + tape_lvl;
        return acc;
    endfunction

endpackage

// File: rtl/sd_modulator.sv
// -----------------------------------------------------------------------------
// sd_modulator
// First-order error-feedback sigma-delta modulator. Each cycle the residue
// (accumulator without its carry bit) is added to the mix word; the carry
// becomes the output bit, so over 2^MIX_W cycles the number of ones equals
// the mix value exactly.
// Ports:
//   cpu_clock : clock
//   reset     : asynchronous active-low reset
//   mix       : unsigned input level, MIX_W bits
//   sd_bit    : 1-bit output stream, straight from the accumulator register
// -----------------------------------------------------------------------------
module sd_modulator
    import covox_pkg::*;
(
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic [MIX_W-1:0] mix,
    output logic             sd_bit
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;

    // The previous carry is dropped: only the residue feeds back.
    assign acc_next = {1'b0, acc_reg[ACC_W-2:0]} + {{(ACC_W-MIX_W){1'b0}}, mix};

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign sd_bit = acc_reg[ACC_W-1];

endmodule

// File: rtl/covox_sd_dac.sv
// -----------------------------------------------------------------------------
// covox_sd_dac
// Audio back-end: captures the Covox sample written by the CPU, mixes it with
// the beeper and tapeout levels and drives a 1-bit sigma-delta stream for an
// external RC filter. An idle timer mutes the Covox channel when the CPU
// stops writing samples.
// Parameters:
//   BEEP_LVL : mix weight of the beeper (BEEP_LVL + TAPE_LVL <= 256)
//   TAPE_LVL : mix weight of tapeout
//   IDLE_W   : idle counter width; mute after 2^IDLE_W-1 cycles without write
// Ports:
//   cpu_clock  : clock
//   reset      : asynchronous active-low reset
//   covox      : active-low Covox write strobe from the decoder
//   d          : CPU data bus
//   beeper     : beeper level
//   tapeout    : tapeout level
//   audio_out  : sigma-delta bitstream
//   covox_idle : high while the Covox channel is muted
//   sample     : committed Covox sample
// -----------------------------------------------------------------------------
module covox_sd_dac
    import covox_pkg::*;
#(
    parameter int BEEP_LVL = 192,
    parameter int TAPE_LVL = 64,
    parameter int IDLE_W   = 16
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       covox,
    input  logic [7:0] d,
    input  logic       beeper,
    input  logic       tapeout,
    output logic       audio_out,
    output logic       covox_idle,
    output logic [7:0] sample
);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = '1;
    localparam logic [IDLE_W-1:0] IDLE_PRE   = IDLE_LIMIT - 1'b1;
    localparam logic [MIX_W-1:0]  BEEP_W     = MIX_W'(BEEP_LVL);
    localparam logic [MIX_W-1:0]  TAPE_W     = MIX_W'(TAPE_LVL);

    logic              cov_q_reg;
    logic [7:0]        hold_reg;
    logic [7:0]        sample_reg;
    logic [7:0]        sample_next;
    logic              beep_q_reg;
    logic              tape_q_reg;
    logic [IDLE_W-1:0] idle_cnt_reg;
    logic [IDLE_W-1:0] idle_cnt_next;
    logic              idle_reg;
    logic              idle_next;
    logic              commit;
    logic [MIX_W-1:0]  mix;

    // Strobe rising edge. cov_q resets to 1, so a strobe already low when
    // reset releases cannot produce a commit until it really rises.
    assign commit = ~cov_q_reg & covox;

    // Commit has priority over the idle limit being reached on the same edge.
    always_comb begin
        sample_next   = sample_reg;
        idle_cnt_next = idle_cnt_reg;
        idle_next     = idle_reg;
        if (commit) begin
            sample_next   = hold_reg;
            idle_cnt_next = '0;
            idle_next     = 1'b0;
        end else if (idle_cnt_reg != IDLE_LIMIT) begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
            if (idle_cnt_reg == IDLE_PRE) begin
                sample_next = 8'h00;
                idle_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            cov_q_reg    <= 1'b1;
            hold_reg     <= 8'h00;
            sample_reg   <= 8'h00;
            beep_q_reg   <= 1'b0;
            tape_q_reg   <= 1'b0;
            idle_cnt_reg <= '0;
            idle_reg     <= 1'b0;
        end else begin
            cov_q_reg    <= covox;
            if (!covox) begin
                hold_reg <= d;
            end
            sample_reg   <= sample_next;
            beep_q_reg   <= beeper;
            tape_q_reg   <= tapeout;
            idle_cnt_reg <= idle_cnt_next;
            idle_reg     <= idle_next;
        end
    end

    assign mix = mix_sum(sample_reg, beep_q_reg, tape_q_reg, BEEP_W, TAPE_W);

    sd_modulator u_mod (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .mix       (mix),
        .sd_bit    (audio_out)
    );

    assign sample     = sample_reg;
    assign covox_idle = idle_reg;

endmodule

// File: tb/tb_covox_sd_dac.sv
// -----------------------------------------------------------------------------
// tb_covox_sd_dac
// Two instances share the stimulus: dut_a with the default idle width (never
// times out during this run) and dut_b with IDLE_W = 4 for the idle checks.
// -----------------------------------------------------------------------------
module tb_covox_sd_dac;

    logic       cpu_clock = 1'b0;
    logic       reset     = 1'b0;
    logic       covox     = 1'b1;
    logic [7:0] d         = 8'h00;
    logic       beeper    = 1'b0;
    logic       tapeout   = 1'b0;

    logic       audio_out_a, covox_idle_a;
    logic [7:0] sample_a;
    logic       audio_out_b, covox_idle_b;
    logic [7:0] sample_b;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clock = ~cpu_clock;

    covox_sd_dac dut_a (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .covox      (covox),
        .d          (d),
        .beeper     (beeper),
        .tapeout    (tapeout),
        .audio_out  (audio_out_a),
        .covox_idle (covox_idle_a),
        .sample     (sample_a)
    );

    covox_sd_dac #(.IDLE_W(4)) dut_b (
        .cpu_clock  (cpu_clock),
        .reset      (reset),
        .covox      (covox),
        .d          (d),
        .beeper     (beeper),
        .tapeout    (tapeout),
        .audio_out  (audio_out_b),
        .covox_idle (covox_idle_b),
        .sample     (sample_b)
    );

    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    // Strobe low for n edges with data v, then rise; commit on the final tick.
    task automatic do_write(input logic [7:0] v, input int n);
        covox = 1'b0;
        d     = v;
        repeat (n) tick();
        covox = 1'b1;
        tick();
        $display("write 0x%02h strobe=%0d cycles sample_a=0x%02h", v, n, sample_a);
    endtask

    // Count ones on one instance's output over n cycles; also report whether
    // every consecutive pair differed.
    task automatic count_ones(input bit use_b, input int n, output int ones, output bit alt);
        logic prev;
        logic cur;
        ones = 0;
        alt  = 1'b1;
        prev = use_b ? audio_out_b : audio_out_a;
        for (int i = 0; i < n; i++) begin
            tick();
            cur = use_b ? audio_out_b : audio_out_a;
            if (cur) ones++;
            if (cur == prev) alt = 1'b0;
            prev = cur;
        end
    endtask

    task automatic test_reset();
        int  waited;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        do_write(8'h77, 2);
        checks++;
        if (sample_a !== 8'h77) begin
            errors++;
            $display("FAIL pre_reset_sample got=0x%02h exp=0x77", sample_a);
        end
        beeper = 1'b1;
        repeat (20) tick();
        checks++;
        if (covox_idle_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_idle got=%b exp=1", covox_idle_b);
        end
        waited = 0;
        while (audio_out_a !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        checks++;
        if (audio_out_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_audio got=%b exp=1", audio_out_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (sample_a !== 8'h00 || sample_b !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_sample got=0x%02h/0x%02h exp=0x00", sample_a, sample_b);
        end
        checks++;
        if (audio_out_a !== 1'b0 || covox_idle_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outs audio=%b idle=%b exp=0/0", audio_out_a, covox_idle_b);
        end
        $display("reset asserted mid-cycle sample=0x%02h audio=%b idle_b=%b", sample_a, audio_out_a, covox_idle_b);
        beeper = 1'b0;
        covox  = 1'b0;
        d      = 8'h5A;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (sample_a !== 8'h00) begin
            errors++;
            $display("FAIL no_spurious_commit got=0x%02h exp=0x00", sample_a);
        end
        covox = 1'b1;
        tick();
        checks++;
        if (sample_a !== 8'h5A) begin
            errors++;
            $display("FAIL reset_midwrite_commit got=0x%02h exp=0x5a", sample_a);
        end
        $display("reset mid-write commit sample=0x%02h", sample_a);
    endtask

    task automatic test_covox_write();
        covox = 1'b0;
        d     = 8'h3C;
        tick();
        tick();
        d = 8'hA5;
        tick();
        covox = 1'b1;
        checks++;
        if (sample_a !== 8'h5A) begin
            errors++;
            $display("FAIL write_before_rise got=0x%02h exp=0x5a", sample_a);
        end
        tick();
        checks++;
        if (sample_a !== 8'hA5 || covox_idle_a !== 1'b0) begin
            errors++;
            $display("FAIL write_commit got=0x%02h idle=%b exp=0xa5 idle=0", sample_a, covox_idle_a);
        end
        $display("write 3-cycle strobe sample=0x%02h idle=%b", sample_a, covox_idle_a);
    endtask

    task automatic test_long_low();
        covox = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = 8'(i);
            tick();
        end
        checks++;
        if (sample_a !== 8'hA5) begin
            errors++;
            $display("FAIL long_low_no_commit got=0x%02h exp=0xa5", sample_a);
        end
        covox = 1'b1;
        tick();
        checks++;
        if (sample_a !== 8'd19) begin
            errors++;
            $display("FAIL long_low_commit got=0x%02h exp=0x13", sample_a);
        end
        $display("long strobe commit sample=0x%02h", sample_a);
    endtask

    task automatic test_density();
        int ones;
        bit alt;
        do_write(8'h00, 1);
        beeper  = 1'b1;
        tapeout = 1'b1;
        tick();
        tick();
        count_ones(1'b0, 512, ones, alt);
        checks++;
        if (ones != 256) begin
            errors++;
            $display("FAIL density_256 got=%0d exp=256", ones);
        end
        checks++;
        if (!alt) begin
            errors++;
            $display("FAIL density_256_alternate got=no exp=yes");
        end
        $display("density mix=256 ones=%0d alternating=%0d", ones, alt);

        beeper  = 1'b0;
        tapeout = 1'b0;
        do_write(8'hFF, 1);
        tick();
        tick();
        count_ones(1'b0, 512, ones, alt);
        checks++;
        if (ones != 255) begin
            errors++;
            $display("FAIL density_255 got=%0d exp=255", ones);
        end
        $display("density mix=255 ones=%0d", ones);

        do_write(8'h00, 1);
        tick();
        ones = audio_out_a ? 1 : 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (audio_out_a) ones++;
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL density_zero got=%0d exp=0", ones);
        end
        $display("density mix=0 ones=%0d over 32", ones);
    endtask

    task automatic test_idle();
        int ones;
        bit alt;
        beeper  = 1'b0;
        tapeout = 1'b0;
        do_write(8'h80, 1);
        repeat (14) tick();
        checks++;
        if (covox_idle_b !== 1'b0 || sample_b !== 8'h80) begin
            errors++;
            $display("FAIL idle_edge14 idle=%b sample=0x%02h exp=0 0x80", covox_idle_b, sample_b);
        end
        tick();
        checks++;
        if (covox_idle_b !== 1'b1 || sample_b !== 8'h00) begin
            errors++;
            $display("FAIL idle_edge15 idle=%b sample=0x%02h exp=1 0x00", covox_idle_b, sample_b);
        end
        $display("idle at edge 15 idle=%b sample=0x%02h", covox_idle_b, sample_b);
        beeper = 1'b1;
        tick();
        tick();
        count_ones(1'b1, 512, ones, alt);
        checks++;
        if (ones != 192) begin
            errors++;
            $display("FAIL idle_beeper_density got=%0d exp=192", ones);
        end
        checks++;
        if (covox_idle_b !== 1'b1 || sample_b !== 8'h00) begin
            errors++;
            $display("FAIL idle_held idle=%b sample=0x%02h exp=1 0x00", covox_idle_b, sample_b);
        end
        $display("idle beeper ones=%0d", ones);
        beeper = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_write(8'h22, 1);
        repeat (13) tick();
        covox = 1'b0;
        d     = 8'h11;
        tick();
        checks++;
        if (covox_idle_b !== 1'b0 || sample_b !== 8'h22) begin
            errors++;
            $display("FAIL simul_before idle=%b sample=0x%02h exp=0 0x22", covox_idle_b, sample_b);
        end
        covox = 1'b1;
        tick();
        checks++;
        if (covox_idle_b !== 1'b0 || sample_b !== 8'h11) begin
            errors++;
            $display("FAIL simul_commit_wins idle=%b sample=0x%02h exp=0 0x11", covox_idle_b, sample_b);
        end
        repeat (14) tick();
        checks++;
        if (covox_idle_b !== 1'b0) begin
            errors++;
            $display("FAIL simul_counter_cleared14 idle=%b exp=0", covox_idle_b);
        end
        tick();
        checks++;
        if (covox_idle_b !== 1'b1) begin
            errors++;
            $display("FAIL simul_counter_cleared15 idle=%b exp=1", covox_idle_b);
        end
        $display("simultaneous commit/limit sample=0x%02h then idle=%b", sample_b, covox_idle_b);
    endtask

    initial begin
        test_reset();
        test_covox_write();
        test_long_low();
        test_density();
        test_idle();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/covox_sd_dac.md
# covox_sd_dac

Audio back-end of the dual-YM2149 CPLD board, directly downstream of the port decoder. It latches the 8-bit Covox sample written to port 0x00FB and mixes it with the beeper and tapeout levels from port 0x00FE. The mixed value is converted to a 1-bit first-order sigma-delta stream for an external RC filter. An idle timer mutes the Covox channel when the CPU stops writing samples.

## Interface
Parameters:
- BEEP_LVL, 192: mix weight added when beeper is high.
- TAPE_LVL, 64: mix weight added when tapeout is high. Constraint: BEEP_LVL + TAPE_LVL ≤ 256.
- IDLE_W, 16: width of the idle counter. The idle limit is 2^IDLE_W − 1 cycles.

Ports:
- cpu_clock  in  1  single clock for the whole block (3.5/7 MHz CPU clock).
- reset  in  1  asynchronous, active-low reset.
- covox  in  1  active-low Covox write strobe from the decoder (low while IORQ+WR to 0x00FB).
- d  in  8  CPU data bus.
- beeper  in  1  beeper level from the decoder's port-0xFE latch.
- tapeout  in  1  tapeout level from the same latch.
- audio_out  out  1  sigma-delta bitstream.
- covox_idle  out  1  high while the Covox channel is muted by the idle timer.
- sample  out  8  current committed Covox sample (debug/monitor).

## Operation
- Write capture:
  - cov_q is covox registered (reset value 1).
  - At every edge where covox == 0: hold <= d.
  - Commit condition: cov_q == 0 and covox == 1 (strobe rising edge).
  - On commit: sample <= hold; idle counter cleared; covox_idle <= 0.
  - The committed value is the data bus at the last edge with covox low.
- Level registers: beeper and tapeout are registered once (beep_q, tape_q) before mixing.
- Mixer (9 bits, unsigned, never overflows): mix = sample + (beep_q ? BEEP_LVL : 0) + (tape_q ? TAPE_LVL : 0).
- Modulator:
  - 10-bit accumulator, acc <= {1'b0, acc[8:0]} + {1'b0, mix}.
  - audio_out = acc[9], taken from the register with no combinational path.
  - With mix constant for 512 cycles, the number of ones equals mix exactly (after the first cycle at the new value).
- Idle timer:
  - The counter increments every cycle without a commit and saturates at 2^IDLE_W − 1.
  - On the edge where it reaches the limit: sample <= 0 and covox_idle <= 1.
  - beeper and tapeout remain audible while idle.
- Boundary cases:
  - Commit and idle-limit on the same edge: the commit wins. The sample loads hold, and the counter and covox_idle clear.
  - Reset mid-write (covox low across reset release): cov_q resets to 1, so no spurious commit occurs. The remaining strobe is captured and committed normally.
  - Strobe only one cycle low: still a valid commit (hold was loaded on that edge).
  - covox held low indefinitely: hold tracks d and no commit occurs. The idle timer keeps running.

## Timing
- Reset values: hold 0, sample 0, cov_q 1, beep_q 0, tape_q 0, acc 0, audio_out 0, idle counter 0, covox_idle 0.
- Strobe rising edge sampled at edge N → sample valid after edge N.
- mix changes combinationally from sample, beep_q and tape_q → acc reflects the new value at edge N+1.
- beeper/tapeout input change → beep_q/tape_q at the next edge → acc one edge later.
- Idle: with no commit, covox_idle rises 2^IDLE_W − 1 edges after the last commit (or after reset release).

## Structure
- Shared package covox_pkg: MIX_W = 9, ACC_W = 10, COVOX_PORT = 8'hFB, BEEP_PORT = 8'hFE. The decoder uses the same port constants.
- One sub-module, sd_modulator: ACC_W-bit first-order error-feedback modulator, with inputs mix[MIX_W-1:0], cpu_clock and reset, and output bit.
- The capture, level registers, mixer and idle timer stay in covox_sd_dac.

## Test plan
- Reset: assert reset low mid-stream → all outputs 0 immediately (asynchronous). Release with covox low and d = 0x5A, then covox high → sample = 0x5A, no earlier commit.
- Covox write: covox low 3 cycles with d = 0x3C, 0x3C, 0xA5, then high → sample = 0xA5 one edge after the strobe rise; covox_idle = 0.
- Density: sample 0x00, beeper = 1, tapeout = 1 (mix 256) → audio_out alternates 0/1 with exactly 256 ones per 512 cycles.
- Density full-scale: sample 0xFF, beeper = 0, tapeout = 0 → 255 ones per 512 cycles. Then sample 0x00 with both levels low → all zeros after one cycle.
- Idle (IDLE_W = 4): commit 0x80, then no writes → covox_idle = 1 and sample = 0 at the 15th edge. With beeper = 1, 192 ones per 512 cycles continue.
- Simultaneous: arrange a strobe rise on the same edge the counter hits its limit, with hold = 0x11 → sample = 0x11, covox_idle = 0, counter = 0.
